// File: rtl/mux_pkg.sv
// Mode encodings and the rotating-priority search shared by the channel mux.
package mux_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   MAX_N       = 64;

  // First set bit scanning last+1, last+2, ..., last (mod n); -1 when req is empty.
  function automatic int rr_first(input logic [MAX_N-1:0] req, input int n, input int last);
    int idx;
    rr_first = -1;
    for (int k = MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) rr_first = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant: static channel select or rotating priority after `last`.
// Zero latency; the caller owns the `last` pointer and the load enable.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  int pick;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pick      = -1;
    case (mode)
      MODE_STATIC: begin
        // Out-of-range selects (non-power-of-two N) never grant.
        if (int'(sel) < N) begin
          if (req[sel]) pick = int'(sel);
        end
      end
      MODE_RR: pick = rr_first(MAX_N'(req), N, int'(last));
      default: pick = -1;
    endcase
    if (pick >= 0) begin
      gnt_valid = 1'b1;
      gnt_idx   = SELW'(pick);
    end
  end

endmodule

// File: rtl/rr_mux_demux.sv
// N-to-1 stream mux (static or round-robin) and 1-to-N demux, one register stage each.
// 1-cycle latency both ways; output stalls hold data and drop all upstream readies.
module rr_mux_demux
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SELW-1:0]    d_sel,
  input  logic               d_valid,
  output logic               d_ready,
  output logic [N*WIDTH-1:0] d_out,
  output logic [N-1:0]       d_out_valid,
  input  logic [N-1:0]       d_out_ready
);

  logic             gnt_valid;
  logic [SELW-1:0]  gnt_idx;
  logic             ld;
  logic             mux_xfer;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             full_q, full_d;
  logic [SELW-1:0]  dest_q, dest_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_ok;
  logic             d_xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .last      (last_q),
    .mode      (mode),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // ---------------- mux side ----------------
  assign ld       = !out_valid_q || out_ready;
  assign mux_xfer = ld && gnt_valid && !rst;

  always_comb begin
    in_ready = '0;
    if (mux_xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    last_d      = last_q;
    if (ld) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        out_chan_d = gnt_idx;
        last_d     = gnt_idx;
      end
    end
  end

  // last resets to N-1 so channel 0 wins the first round-robin grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_q      <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

  // ---------------- demux side ----------------
  assign sel_ok  = int'(d_sel) < N;
  assign d_ready = !rst && (!full_q || d_out_ready[dest_q]);
  assign d_xfer  = d_valid && d_ready;

  // A word addressed past the last lane is accepted and discarded.
  always_comb begin
    full_d = full_q;
    dest_d = dest_q;
    data_d = data_q;
    if (d_xfer) begin
      full_d = sel_ok;
      if (sel_ok) begin
        dest_d = d_sel;
        data_d = d_in;
      end
    end else if (full_q && d_out_ready[dest_q]) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    d_out       = '0;
    d_out_valid = '0;
    if (full_q) begin
      d_out[int'(dest_q)*WIDTH +: WIDTH] = data_q;
      d_out_valid[dest_q]                = 1'b1;
    end
  end

  a_in_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_chan)));

endmodule

// File: tb/tb_rr_mux_demux.sv
// Randomized and directed bench for rr_mux_demux against a transaction-level reference model.
module tb_rr_mux_demux;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   d_in;
  logic [SELW-1:0]    d_sel;
  logic               d_valid;
  logic               d_ready;
  logic [N*WIDTH-1:0] d_out;
  logic [N-1:0]       d_out_valid;
  logic [N-1:0]       d_out_ready;

  rr_mux_demux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .sel         (sel),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d_in        (d_in),
    .d_sel       (d_sel),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_out       (d_out),
    .d_out_valid (d_out_valid),
    .d_out_ready (d_out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_out_valid;
  logic [7:0] m_out_data;
  int         m_out_chan;
  int         m_last;
  bit         m_full;
  int         m_dest;
  logic [7:0] m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out_valid = 0; m_out_data = 0; m_out_chan = 0; m_last = N - 1;
    m_full = 0; m_dest = 0; m_data = 0;
  endtask

  task automatic model_grant(output bit gv, output int g);
    gv = 0; g = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) begin gv = 1; g = int'(sel); end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!gv && in_valid[(m_last + k) % N]) begin gv = 1; g = (m_last + k) % N; end
      end
    end
  endtask

  // Entered just after a rising edge with inputs already driven; leaves just after the next one.
  task automatic cycle();
    bit gv;
    int g;
    bit ld;
    bit exp_dr;
    logic [N-1:0]       exp_ir;
    logic [N*WIDTH-1:0] exp_dout;
    logic [N-1:0]       exp_dov;
    #2;
    model_grant(gv, g);
    ld = !m_out_valid || out_ready;
    exp_ir = '0;
    if (ld && gv) exp_ir[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    check("out_valid", 64'(out_valid), 64'(m_out_valid));
    check("out_data", 64'(out_data), 64'(m_out_data));
    check("out_chan", 64'(out_chan), 64'(m_out_chan));
    exp_dr = !m_full || d_out_ready[m_dest];
    exp_dout = '0;
    exp_dov = '0;
    if (m_full) begin
      exp_dout[m_dest*WIDTH +: WIDTH] = m_data;
      exp_dov[m_dest] = 1'b1;
    end
    check("d_ready", 64'(d_ready), 64'(exp_dr));
    check("d_out", 64'(d_out), 64'(exp_dout));
    check("d_out_valid", 64'(d_out_valid), 64'(exp_dov));
    if (ld) begin
      m_out_valid = gv;
      if (gv) begin
        m_out_data = in_data[g*WIDTH +: WIDTH];
        m_out_chan = g;
        m_last     = g;
      end
    end
    if (d_valid && exp_dr) begin
      if (int'(d_sel) < N) begin m_full = 1; m_dest = int'(d_sel); m_data = d_in; end
      else m_full = 0;
    end else if (m_full && d_out_ready[m_dest]) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    mode        = 1'($urandom_range(0, 1));
    sel         = SELW'($urandom_range(0, N - 1));
    in_data     = {$urandom};
    in_valid    = N'($urandom);
    out_ready   = ($urandom_range(0, 3) != 0);
    d_in        = WIDTH'($urandom);
    d_sel       = SELW'($urandom_range(0, N - 1));
    d_valid     = 1'($urandom_range(0, 1));
    d_out_ready = N'($urandom);
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  logic [7:0]      held;
  logic [SELW-1:0] held_chan;

  initial begin
    rst = 1; mode = 0; sel = 0; in_data = '0; in_valid = '0; out_ready = 0;
    d_in = '0; d_sel = '0; d_valid = 0; d_out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    repeat (30) begin randomize_inputs(); cycle(); end

    // Mid-cycle reset: all outputs drop without waiting for an edge
    in_valid = '0; d_valid = 0;
    #2;
    rst = 1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_chan", 64'(out_chan), 64'(0));
    check("rst_d_out_valid", 64'(d_out_valid), 64'(0));
    check("rst_d_out", 64'(d_out), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_d_ready", 64'(d_ready), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;

    // Round-robin after reset starts at channel 0
    mode = 1; in_valid = 4'hF; out_ready = 1; in_data = 32'h13121110;
    d_valid = 0; d_out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_seq", 64'(out_chan), 64'(rr_exp[i]));
    end

    // Static select on an idle channel gives nothing, then the word appears
    mode = 0; sel = 2; in_valid = 4'b1011;
    cycle();
    check("static_nogrant", 64'(out_valid), 64'(0));
    in_valid = 4'hF; in_data = 32'h44A52211;
    cycle();
    check("static_data", 64'(out_data), 64'(8'hA5));
    check("static_chan", 64'(out_chan), 64'(2));

    // Backpressure: three stalled cycles, then rotation resumes
    mode = 1; in_valid = 4'hF; out_ready = 1; in_data = 32'hD4C3B2A1;
    cycle();
    held = out_data; held_chan = out_chan;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_data", 64'(out_data), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1;
    cycle();
    check("bp_resume", 64'(out_chan), 64'((int'(held_chan) + 1) % N));

    // Sparse round-robin from last=0
    mode = 0; sel = 0; in_valid = 4'b0001;
    cycle();
    mode = 1; in_valid = 4'b1001;
    cycle(); check("sparse0", 64'(out_chan), 64'(3));
    cycle(); check("sparse1", 64'(out_chan), 64'(0));
    cycle(); check("sparse2", 64'(out_chan), 64'(3));

    // Demux: blocked lane, then back-to-back send without a bubble
    in_valid = '0;
    d_out_ready = 4'b0000; d_valid = 1; d_sel = 1; d_in = 8'h3C;
    cycle();
    d_sel = 3; d_in = 8'h5A;
    #1;
    check("dmx_valid", 64'(d_out_valid), 64'(4'b0010));
    check("dmx_lane1", 64'(d_out[15:8]), 64'(8'h3C));
    check("dmx_blocked", 64'(d_ready), 64'(0));
    cycle();
    #1;
    check("dmx_still_blocked", 64'(d_ready), 64'(0));
    d_out_ready = 4'b0010;
    #1;
    check("dmx_released", 64'(d_ready), 64'(1));
    cycle();
    #1;
    check("dmx_b2b_valid", 64'(d_out_valid), 64'(4'b1000));
    check("dmx_b2b_lane3", 64'(d_out[31:24]), 64'(8'h5A));
    d_valid = 0; d_out_ready = 4'hF;
    cycle();
    check("dmx_drained", 64'(d_out_valid), 64'(0));

    // Mode switch while stalled keeps the held word; next grant follows static sel
    mode = 1; in_valid = 4'hF; out_ready = 1; in_data = 32'h88776655;
    cycle();
    held = out_data;
    out_ready = 0; mode = 0; sel = 0;
    cycle(); check("ms_hold0", 64'(out_data), 64'(held));
    cycle(); check("ms_hold1", 64'(out_data), 64'(held));
    out_ready = 1;
    cycle();
    check("ms_next_chan", 64'(out_chan), 64'(0));
    check("ms_next_data", 64'(out_data), 64'(8'h55));

    repeat (500) begin randomize_inputs(); cycle(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
